sprite_draw_ctrl: RTL
=====================

Name: sprite_draw_ctrl

Overview:
Sequences a full sprite blit from the object sprite ROM (32x32, 10-bit address, 8-bit 3-3-2 colour) into the VGA adapter's pixel-write port. On start it walks every sprite address in raster order and emits one plot per pixel at screen position (x0+col, y0+row). It honours plot_ready backpressure from the VGA-side arbiter. It sits between the game FSM (start/done) and the shared VGA write port.

Parameters:
SPR_W, 32, sprite width in pixels (power of 2)
SPR_H, 32, sprite height in pixels (power of 2)
ADDR_W, 10, sprite ROM address width, equal to log2(SPR_W*SPR_H)
COLOR_W, 8, pixel colour width
X_W, 8, screen x coordinate width (160-wide screen)
Y_W, 7, screen y coordinate width (120-high screen)
KEY_COLOR, 8'hE3, transparent colour; used only when SPRITE_TRANSPARENCY_EN is defined

Ports:
Clock  in  1  system clock
Resetn  in  1  reset; synchronous, active-low
start  in  1  one-cycle request to draw; sampled only in IDLE
x0  in  X_W  sprite origin x; latched on accepted start
y0  in  Y_W  sprite origin y; latched on accepted start
mem_addr  out  ADDR_W  sprite ROM address; ROM returns data one cycle later
mem_data  in  COLOR_W  sprite ROM read data
plot  out  1  pixel write valid
plot_x  out  X_W  pixel x
plot_y  out  Y_W  pixel y
plot_color  out  COLOR_W  pixel colour; equals mem_data while plot=1
plot_ready  in  1  VGA side accepts the pixel in the cycle where plot & plot_ready
busy  out  1  high from the cycle after an accepted start through DONE
done  out  1  one-cycle pulse at completion

Behaviour:
- States: IDLE, FETCH, PLOT, DONE. Registered pixel counter F (ADDR_W bits). col = F[log2 SPR_W - 1:0], row = upper bits of F.
- Reset: state=IDLE, F=0, latched origin=0. Outputs plot=0, busy=0, done=0, mem_addr=0, plot_x=0, plot_y=0.
- Resetn low in any state returns to IDLE on the next edge. The in-progress blit is abandoned and no done pulse is issued.
- IDLE: start=1 latches x0/y0, clears F, and moves to FETCH. Otherwise stays in IDLE.
- FETCH: lasts one cycle. mem_addr=F. Moves to PLOT.
- PLOT: plot=1. mem_addr is held at F. plot_color=mem_data. plot_x=(x0_l+col) mod 2^X_W. plot_y=(y0_l+row) mod 2^Y_W; coordinates are truncated and wrap, with no clipping.
- PLOT, plot_ready=0: stay in PLOT. All outputs hold stable.
- PLOT, plot_ready=1 and F==2^ADDR_W-1: go to DONE.
- PLOT, plot_ready=1 otherwise: F<=F+1 and go to FETCH.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Throughput: one pixel per 2 cycles with plot_ready=1. For start accepted at edge t0, pixel k is in PLOT during cycle t0+2+2k. done is high in cycle t0+2049.
- start while not in IDLE is ignored, with no queueing. x0/y0 changes after the accepting edge have no effect.
- plot is 0 in every state except PLOT.

Optional Feature:
SPRITE_TRANSPARENCY_EN:
- Defined: in PLOT, when mem_data==KEY_COLOR, plot stays 0 and the pixel counts as accepted that cycle. F advances (or the FSM goes to DONE) regardless of plot_ready.
- Undefined: every pixel is plotted. KEY_COLOR is unused.

Decomposition:
- Shared package sprite_pkg holds:
  - state encoding constants S_IDLE, S_FETCH, S_PLOT, S_DONE (2 bits)
  - SPR_W, SPR_H, ADDR_W
  - screen size constants SCREEN_W=160, SCREEN_H=120
- One natural sub-module: sprite_pixel_counter. It holds the ADDR_W counter with sync clear and enable, outputs col/row/last, and is reusable by other blit controllers.

Test Plan:
- ROM model data=addr[7:0], plot_ready=1, start with x0=10, y0=20 -> first plot at (10,20) colour 0x00; pixel 33 at (11,21) colour 0x21; exactly 1024 plots; done is a single pulse at t0+2049; busy falls the cycle after.
- Backpressure: plot_ready toggles on a pseudo-random pattern -> each pixel accepted exactly once, in order; plot_x, plot_y and plot_color stable while stalled; total accepted = 1024.
- Wrap: x0=240, y0=110 -> pixel col=31,row=0 at x=15; row=31 at y=13 (mod 128); no error.
- start pulsed at pixel 500, and x0 changed during the blit -> ignored; all coordinates use the originally latched origin; only one done.
- Resetn low at pixel 300 -> next cycle plot=0, busy=0, no done; a new start then draws from pixel 0.
- SPRITE_TRANSPARENCY_EN defined, ROM returns 8'hE3 for even addresses -> 512 plots (odd addresses only), each skipped pixel still costs 2 cycles, done still issued.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and state encoding for the sprite blit
// controller and its pixel counter.
//   Sprite geometry  : SPR_W x SPR_H, ADDR_W-bit ROM address
//   Pixel format     : COLOR_W-bit 3-3-2 colour
//   Screen           : SCREEN_W x SCREEN_H, X_W/Y_W-bit coordinates
//   KEY_COLOR        : transparent colour, only meaningful when
//                      SPRITE_TRANSPARENCY_EN is defined
package sprite_pkg;

  localparam int SPR_W    = 32;
  localparam int SPR_H    = 32;
  localparam int ADDR_W   = 10;
  localparam int COLOR_W  = 8;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [COLOR_W-1:0] KEY_COLOR = 8'hE3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLOT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_draw_ctrl_pixel_counter.sv
// sprite_pixel_counter: raster-order pixel index for a SPR_W x SPR_H blit.
// Ports:
//   Clock, Resetn : clock, synchronous active-low reset
//   clear         : synchronous clear to pixel 0 (wins over en)
//   en            : advance to the next pixel
//   count         : current pixel index {row, col}
//   col, row      : column / row split of count
//   last          : count is the final pixel of the sprite
module sprite_pixel_counter #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  localparam int CW = $clog2(SPR_W),
  localparam int RW = $clog2(SPR_H),
  localparam int AW = CW + RW
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          clear,
  input  logic          en,
  output logic [AW-1:0] count,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [AW-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (!Resetn)    cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= cnt + AW'(1);
  end

  // Power-of-2 dimensions make the index split a plain bit slice.
  assign count = cnt;
  assign col   = cnt[CW-1:0];
  assign row   = cnt[AW-1:CW];
  assign last  = &cnt;

endmodule

// File: rtl/sprite_draw_ctrl.sv
// sprite_draw_ctrl: walks the 32x32 sprite ROM in raster order and emits one
// pixel write per address at (x0+col, y0+row), honouring plot_ready.
// Ports:
//   Clock, Resetn       : clock, synchronous active-low reset
//   start, x0, y0       : draw request and origin, taken only in IDLE
//   mem_addr, mem_data  : sprite ROM port, data valid one cycle after address
//   plot, plot_x/y/color: pixel write to the VGA side
//   plot_ready          : VGA side accepts when plot & plot_ready
//   busy, done          : blit in progress / one-cycle completion pulse
// Build option: SPRITE_TRANSPARENCY_EN -- pixels equal to KEY_COLOR are
//   dropped (no plot) but still consume their two-cycle slot.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | ROM address presented, data arrives next cycle
// PLOT    | pixel offered on the write port until accepted
// DONE    | one-cycle completion pulse
module sprite_draw_ctrl
  import sprite_pkg::*;
(
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_data,
  output logic               plot,
  output logic [X_W-1:0]     plot_x,
  output logic [Y_W-1:0]     plot_y,
  output logic [COLOR_W-1:0] plot_color,
  input  logic               plot_ready,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  state_t             state, state_nx;
  logic [X_W-1:0]     x0_l;
  logic [Y_W-1:0]     y0_l;
  logic [ADDR_W-1:0]  pix;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               last;
  logic               take_start;
  logic               skip;
  logic               accept;

  assign take_start = (state == S_IDLE) && start;

`ifdef SPRITE_TRANSPARENCY_EN
  assign skip = (mem_data == KEY_COLOR);
`else
  assign skip = 1'b0;
`endif

  // A transparent pixel is consumed without waiting on the VGA side.
  assign accept = plot_ready | skip;

  sprite_pixel_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clear  (take_start),
    .en     ((state == S_PLOT) && accept && !last),
    .count  (pix),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      x0_l <= '0;
      y0_l <= '0;
    end else if (take_start) begin
      x0_l <= x0;
      y0_l <= y0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: state_nx = S_PLOT;
      S_PLOT:  if (accept) state_nx = last ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Coordinates wrap at the bus width; no clipping to the visible screen.
  always_comb begin
    plot       = (state == S_PLOT) && !skip;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    mem_addr   = pix;
    plot_color = mem_data;
    plot_x     = x0_l + X_W'(col);
    plot_y     = y0_l + Y_W'(row);
  end

endmodule
